eth_rx_ctrl: RTL and testbench

RMII receive control for simpleEthernet: the receive-side counterpart of the transmit control FSM.
- Samples the 2-bit RMII receive interface at the 50 MHz reference clock.
- Locks onto preamble/SFD, assembles dibits into bytes (LSB dibit first) and tracks frame fields (DEST_ADDR, SRC_ADDR, LEN_TYPE, DATA).
- Runs a dibit-serial CRC-32 over the frame and reports per-frame status.
- Feeds the RX FIFO and the RX packet parser.

---
 rtl/eth_rx_ctrl.sv | 212 +++++++++++++++++++++
 tb/tb_eth_rx_ctrl.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/eth_rx_ctrl.sv
// rtl/eth_rx_ctrl.sv - RMII receive control: preamble lock, byte assembly, CRC-32 and frame status
//
// Purpose:
//   Samples the 2-bit RMII receive interface, locks onto preamble/SFD,
//   assembles dibits into bytes (LSB dibit first), tracks the frame fields,
//   runs a dibit-serial reflected CRC-32 and reports per-frame status.
//
// Ports:
//   Clk               50 MHz RMII reference clock
//   Rst               synchronous active-high reset
//   Rx_Dv             qualified receive data valid
//   Rxd               RMII receive dibit
//   Rx_Byte           assembled byte
//   Rx_Byte_Vld       one-cycle strobe, Rx_Byte valid
//   Rx_Sof            with Rx_Byte_Vld on the first DA byte
//   Rx_Frame_Done     one-cycle end-of-frame strobe, status updated this cycle
//   Rx_Crc_Err        status: CRC residue mismatch
//   Rx_Align_Err      status: frame ended on a partial byte
//   Rx_Runt_Err       status: too few bytes
//   Rx_Long_Err       status: frame aborted for length
//   Rx_Addr_Hit       status: DA is local unicast or broadcast
//   Rx_Byte_Cnt       status: bytes received after SFD, including FCS
//   Rx_Ctrl_FSM_State current state

package eth_rx_pkg;
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PREAMBLE  = 3'd1,
    DEST_ADDR = 3'd2,
    SRC_ADDR  = 3'd3,
    LEN_TYPE  = 3'd4,
    DATA      = 3'd5,
    DROP      = 3'd6
  } eth_rx_ctrl_state_t;
endpackage

module eth_rx_ctrl
  import eth_rx_pkg::*;
#(
  parameter int          pMIN_PREAMBLE_DIBITS = 8,
  parameter int          pMIN_FRAME_BYTES     = 64,
  parameter int          pMAX_FRAME_BYTES     = 1518,
  parameter logic [47:0] pMAC_ADDR            = 48'h02_00_00_00_00_01
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic               Rx_Dv,
  input  logic [1:0]         Rxd,
  output logic [7:0]         Rx_Byte,
  output logic               Rx_Byte_Vld,
  output logic               Rx_Sof,
  output logic               Rx_Frame_Done,
  output logic               Rx_Crc_Err,
  output logic               Rx_Align_Err,
  output logic               Rx_Runt_Err,
  output logic               Rx_Long_Err,
  output logic               Rx_Addr_Hit,
  output logic [10:0]        Rx_Byte_Cnt,
  output eth_rx_ctrl_state_t Rx_Ctrl_FSM_State
);

  localparam logic [4:0]  MIN_PRE   = 5'(pMIN_PREAMBLE_DIBITS);
  localparam logic [10:0] MIN_BYTES = 11'(pMIN_FRAME_BYTES);
  localparam logic [10:0] MAX_BYTES = 11'(pMAX_FRAME_BYTES);
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

  logic [4:0]  pre_cnt;
  logic [1:0]  dib_cnt;
  logic [10:0] byte_cnt;
  logic [5:0]  shift_reg;
  logic [31:0] crc;
  logic        ucast_ok;
  logic        bcast_ok;

  logic [7:0]  byte_new;
  logic [7:0]  mac_byte;
  logic [10:0] byte_cnt_nxt;
  logic        da_hit;

  // Two LSB-first bit steps of the reflected CRC-32; Rxd[0] is first on the wire.
  function automatic logic [31:0] crc_dibit(input logic [31:0] c, input logic [1:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 2; i++) begin
      r = (r >> 1) ^ ((r[0] ^ d[i]) ? 32'hEDB88320 : 32'h0);
    end
    return r;
  endfunction

  always_comb begin
    byte_new     = {Rxd, shift_reg};
    byte_cnt_nxt = byte_cnt + 11'd1;
    da_hit       = (byte_cnt >= 11'd6) && (ucast_ok || bcast_ok);
    case (byte_cnt[2:0])
      3'd0:    mac_byte = pMAC_ADDR[47:40];
      3'd1:    mac_byte = pMAC_ADDR[39:32];
      3'd2:    mac_byte = pMAC_ADDR[31:24];
      3'd3:    mac_byte = pMAC_ADDR[23:16];
      3'd4:    mac_byte = pMAC_ADDR[15:8];
      3'd5:    mac_byte = pMAC_ADDR[7:0];
      default: mac_byte = 8'h00;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      Rx_Ctrl_FSM_State <= IDLE;
      Rx_Byte           <= 8'h00;
      Rx_Byte_Vld       <= 1'b0;
      Rx_Sof            <= 1'b0;
      Rx_Frame_Done     <= 1'b0;
      Rx_Crc_Err        <= 1'b0;
      Rx_Align_Err      <= 1'b0;
      Rx_Runt_Err       <= 1'b0;
      Rx_Long_Err       <= 1'b0;
      Rx_Addr_Hit       <= 1'b0;
      Rx_Byte_Cnt       <= 11'd0;
      pre_cnt           <= 5'd0;
      dib_cnt           <= 2'd0;
      byte_cnt          <= 11'd0;
      shift_reg         <= 6'd0;
      crc               <= 32'hFFFFFFFF;
      ucast_ok          <= 1'b0;
      bcast_ok          <= 1'b0;
    end else begin
      Rx_Byte_Vld   <= 1'b0;
      Rx_Sof        <= 1'b0;
      Rx_Frame_Done <= 1'b0;

      case (Rx_Ctrl_FSM_State)
        IDLE: begin
          if (Rx_Dv) begin
            if (Rxd == 2'b01) begin
              Rx_Ctrl_FSM_State <= PREAMBLE;
              pre_cnt           <= 5'd1;
            end else begin
              Rx_Ctrl_FSM_State <= DROP;
            end
          end
        end

        PREAMBLE: begin
          if (!Rx_Dv) begin
            Rx_Ctrl_FSM_State <= IDLE;
          end else if (Rxd == 2'b01) begin
            if (pre_cnt != 5'd31) pre_cnt <= pre_cnt + 5'd1;
          end else if (Rxd == 2'b11 && pre_cnt >= MIN_PRE) begin
            Rx_Ctrl_FSM_State <= DEST_ADDR;
            dib_cnt           <= 2'd0;
            byte_cnt          <= 11'd0;
            crc               <= 32'hFFFFFFFF;
            ucast_ok          <= 1'b1;
            bcast_ok          <= 1'b1;
          end else begin
            Rx_Ctrl_FSM_State <= DROP;
          end
        end

        DEST_ADDR, SRC_ADDR, LEN_TYPE, DATA: begin
          if (!Rx_Dv) begin
            Rx_Frame_Done     <= 1'b1;
            Rx_Crc_Err        <= (crc != CRC_RESIDUE);
            Rx_Align_Err      <= (dib_cnt != 2'd0);
            Rx_Runt_Err       <= (byte_cnt < MIN_BYTES);
            Rx_Long_Err       <= 1'b0;
            Rx_Addr_Hit       <= da_hit;
            Rx_Byte_Cnt       <= byte_cnt;
            Rx_Ctrl_FSM_State <= IDLE;
          end else begin
            crc       <= crc_dibit(crc, Rxd);
            shift_reg <= {Rxd, shift_reg[5:2]};
            dib_cnt   <= dib_cnt + 2'd1;
            if (dib_cnt == 2'd3) begin
              if (byte_cnt == MAX_BYTES) begin
                // One byte too many: abort without emitting it.
                Rx_Frame_Done     <= 1'b1;
                Rx_Crc_Err        <= 1'b1;
                Rx_Align_Err      <= 1'b0;
                Rx_Runt_Err       <= 1'b0;
                Rx_Long_Err       <= 1'b1;
                Rx_Addr_Hit       <= da_hit;
                Rx_Byte_Cnt       <= MAX_BYTES;
                Rx_Ctrl_FSM_State <= DROP;
              end else begin
                Rx_Byte     <= byte_new;
                Rx_Byte_Vld <= 1'b1;
                Rx_Sof      <= (byte_cnt == 11'd0);
                byte_cnt    <= byte_cnt_nxt;
                if (Rx_Ctrl_FSM_State == DEST_ADDR) begin
                  if (byte_new != mac_byte) ucast_ok <= 1'b0;
                  if (byte_new != 8'hFF)    bcast_ok <= 1'b0;
                  if (byte_cnt_nxt == 11'd6) Rx_Ctrl_FSM_State <= SRC_ADDR;
                end else if (Rx_Ctrl_FSM_State == SRC_ADDR) begin
                  if (byte_cnt_nxt == 11'd12) Rx_Ctrl_FSM_State <= LEN_TYPE;
                end else if (Rx_Ctrl_FSM_State == LEN_TYPE) begin
                  if (byte_cnt_nxt == 11'd14) Rx_Ctrl_FSM_State <= DATA;
                end
              end
            end
          end
        end

        DROP: begin
          if (!Rx_Dv) Rx_Ctrl_FSM_State <= IDLE;
        end

        default: Rx_Ctrl_FSM_State <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_eth_rx_ctrl.sv
// tb/tb_eth_rx_ctrl.sv - self-checking bench for eth_rx_ctrl

module tb_eth_rx_ctrl;
  import eth_rx_pkg::*;

  localparam logic [47:0] MAC   = 48'h02_00_00_00_00_01;
  localparam logic [47:0] BCAST = 48'hFF_FF_FF_FF_FF_FF;
  localparam logic [47:0] OTHER = 48'h02_00_00_00_00_02;

  logic               Clk = 1'b0;
  logic               Rst;
  logic               Rx_Dv;
  logic [1:0]         Rxd;
  logic [7:0]         Rx_Byte;
  logic               Rx_Byte_Vld;
  logic               Rx_Sof;
  logic               Rx_Frame_Done;
  logic               Rx_Crc_Err;
  logic               Rx_Align_Err;
  logic               Rx_Runt_Err;
  logic               Rx_Long_Err;
  logic               Rx_Addr_Hit;
  logic [10:0]        Rx_Byte_Cnt;
  eth_rx_ctrl_state_t Rx_Ctrl_FSM_State;

  int errors = 0;
  int checks = 0;

  logic [8:0]  byte_q[$];   // {sof, data}
  logic [15:0] done_q[$];   // {crc, align, runt, long, hit, cnt}
  logic [7:0]  frm[$];

  always #10 Clk = ~Clk;

  eth_rx_ctrl dut (
    .Clk(Clk), .Rst(Rst), .Rx_Dv(Rx_Dv), .Rxd(Rxd),
    .Rx_Byte(Rx_Byte), .Rx_Byte_Vld(Rx_Byte_Vld), .Rx_Sof(Rx_Sof),
    .Rx_Frame_Done(Rx_Frame_Done), .Rx_Crc_Err(Rx_Crc_Err),
    .Rx_Align_Err(Rx_Align_Err), .Rx_Runt_Err(Rx_Runt_Err),
    .Rx_Long_Err(Rx_Long_Err), .Rx_Addr_Hit(Rx_Addr_Hit),
    .Rx_Byte_Cnt(Rx_Byte_Cnt), .Rx_Ctrl_FSM_State(Rx_Ctrl_FSM_State)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard side: pop and compare whenever the DUT produces output.
  always @(negedge Clk) begin
    if (Rx_Byte_Vld) begin
      if (byte_q.size() == 0) check("unexpected_byte", {23'd0, Rx_Sof, Rx_Byte}, 32'h1FF);
      else check("byte", {23'd0, Rx_Sof, Rx_Byte}, {23'd0, byte_q.pop_front()});
    end
    if (Rx_Frame_Done) begin
      if (done_q.size() == 0) check("unexpected_done", 32'd1, 32'd0);
      else check("status",
                 {16'd0, Rx_Crc_Err, Rx_Align_Err, Rx_Runt_Err, Rx_Long_Err, Rx_Addr_Hit, Rx_Byte_Cnt},
                 {16'd0, done_q.pop_front()});
    end
  end

  function automatic logic [31:0] fcs_of(input logic [7:0] b[$]);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    foreach (b[i]) begin
      c ^= {24'd0, b[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  task automatic make_frame(input logic [47:0] da, input int total);
    logic [31:0] f;
    frm = {};
    for (int i = 0; i < 6; i++) frm.push_back(da[47-8*i -: 8]);
    frm.push_back(8'h02); frm.push_back(8'hAA); frm.push_back(8'hBB);
    frm.push_back(8'hCC); frm.push_back(8'hDD); frm.push_back(8'hEE);
    frm.push_back(8'h00); frm.push_back(8'h2E);
    for (int i = 14; i < total - 4; i++) frm.push_back(8'(i * 7 + 3));
    f = fcs_of(frm);
    for (int i = 0; i < 4; i++) frm.push_back(f[8*i +: 8]);
  endtask

  task automatic drive(input logic dv, input logic [1:0] d);
    @(negedge Clk);
    Rx_Dv = dv;
    Rxd   = d;
  endtask

  task automatic preamble();
    for (int i = 0; i < 31; i++) drive(1'b1, 2'b01);
    drive(1'b1, 2'b11);
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int k = 0; k < 4; k++) drive(1'b1, b[2*k +: 2]);
  endtask

  task automatic expect_done(input logic crc, align, runt, long_e, hit, input int cnt);
    done_q.push_back({crc, align, runt, long_e, hit, 11'(cnt)});
  endtask

  task automatic send_frame(input bit extra_dibit);
    preamble();
    foreach (frm[i]) begin
      byte_q.push_back({(i == 0), frm[i]});
      send_byte(frm[i]);
    end
    if (extra_dibit) drive(1'b1, 2'b00);
    drive(1'b0, 2'b00);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 2'b00);
  endtask

  task automatic check_drained(input string tag);
    idle(4);
    check({tag, "_bytes_left"}, byte_q.size(), 0);
    check({tag, "_done_left"}, done_q.size(), 0);
    check({tag, "_state"}, 32'(Rx_Ctrl_FSM_State), 32'(IDLE));
  endtask

  initial begin
    Rst = 1'b1; Rx_Dv = 1'b0; Rxd = 2'b00;
    repeat (3) @(negedge Clk);
    check("rst_state", 32'(Rx_Ctrl_FSM_State), 32'(IDLE));
    check("rst_outputs",
          {13'd0, Rx_Byte, Rx_Byte_Vld, Rx_Sof, Rx_Frame_Done, Rx_Crc_Err, Rx_Align_Err,
           Rx_Runt_Err, Rx_Long_Err, Rx_Addr_Hit, Rx_Byte_Cnt}, 32'd0);
    Rst = 1'b0;
    idle(2);

    // Good unicast frame.
    make_frame(MAC, 64);
    expect_done(0, 0, 0, 0, 1, 64);
    send_frame(1'b0);
    check_drained("good");

    // Payload bit error.
    make_frame(MAC, 64);
    frm[20] ^= 8'h01;
    expect_done(1, 0, 0, 0, 1, 64);
    send_frame(1'b0);
    check_drained("crc");

    // Runt with valid CRC.
    make_frame(MAC, 40);
    expect_done(0, 0, 1, 0, 1, 40);
    send_frame(1'b0);
    check_drained("runt");

    // Trailing extra dibit.
    make_frame(MAC, 64);
    expect_done(1, 1, 0, 0, 1, 64);
    send_frame(1'b1);
    check_drained("align");

    // Preamble cut short after 5 dibits.
    for (int i = 0; i < 5; i++) drive(1'b1, 2'b01);
    drive(1'b0, 2'b00);
    check_drained("pre_short");

    // SFD too early, rest of frame ignored.
    for (int i = 0; i < 4; i++) drive(1'b1, 2'b01);
    drive(1'b1, 2'b11);
    check("early_sfd_drop", 32'(Rx_Ctrl_FSM_State), 32'(PREAMBLE));
    for (int i = 0; i < 20; i++) drive(1'b1, 2'(i));
    drive(1'b0, 2'b00);
    check_drained("early_sfd");

    // 1600-byte stream: 1518 emitted, then abort.
    preamble();
    for (int i = 0; i < 1600; i++) begin
      logic [7:0] b;
      b = (i < 6) ? 8'hFF : 8'(i);
      if (i < 1518) byte_q.push_back({(i == 0), b});
      if (i == 1518) expect_done(1, 0, 0, 1, 1, 1518);
      send_byte(b);
      if (i == 1530) check("long_in_drop", 32'(Rx_Ctrl_FSM_State), 32'(DROP));
    end
    drive(1'b0, 2'b00);
    check_drained("long");

    // Reset mid-frame, then a clean broadcast frame.
    make_frame(BCAST, 64);
    preamble();
    for (int i = 0; i < 30; i++) begin
      byte_q.push_back({(i == 0), frm[i]});
      send_byte(frm[i]);
    end
    @(negedge Clk); Rst = 1'b1; Rx_Dv = 1'b0;
    @(negedge Clk); Rst = 1'b0;
    check("rst_mid_state", 32'(Rx_Ctrl_FSM_State), 32'(IDLE));
    check("rst_mid_done", {31'd0, Rx_Frame_Done}, 32'd0);
    expect_done(0, 0, 0, 0, 1, 64);
    send_frame(1'b0);
    check_drained("after_rst");

    // Back-to-back frames, one idle cycle between (the send_frame tail).
    make_frame(OTHER, 64);
    expect_done(0, 0, 0, 0, 0, 64);
    send_frame(1'b0);
    make_frame(MAC, 70);
    expect_done(0, 0, 0, 0, 1, 70);
    send_frame(1'b0);
    check_drained("b2b");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
